acc_writeback_dma: RTL

ACC_WRITEBACK_DMA -- requirements
Module: acc_writeback_dma

---
 rtl/acc_writeback_dma.sv | 126 ++++++++++++
 1 files changed

// File: rtl/acc_writeback_dma.sv
// Buffers accelerator results in a small FIFO and writes them to DRAM over Wishbone,
// one word per command slot, for commands snooped off the CPU bus (one active + one pending).
module acc_writeback_dma #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cpu_wbs_stb_i,
  input  logic                  cpu_wbs_cyc_i,
  input  logic                  cpu_wbs_we_i,
  input  logic [31:0]           cpu_wbs_adr_i,
  input  logic [31:0]           cpu_wbs_dat_i,
  input  logic                  acc_data_valid_o,
  input  logic [DATA_WIDTH-1:0] acc_data_o,
  output logic                  acc_ready_i,
  output logic                  dram_wbs_stb_i,
  output logic                  dram_wbs_cyc_i,
  output logic                  dram_wbs_we_i,
  output logic [31:0]           dram_wbs_adr_i,
  output logic [31:0]           dram_wbs_dat_i,
  input  logic                  dram_wbs_ack_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  drop_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  fifo_full, fifo_empty, push, pop;
  logic                  cmd_hit, cmd_accept;
  logic                  pend_vld;
  logic [7:0]            pend_base, pend_end, cur_addr, end_addr;
  logic                  unused_bits;

  assign unused_bits = ^{cpu_wbs_adr_i[23:0], cpu_wbs_dat_i[31:16], cpu_wbs_dat_i[9:8], cpu_wbs_dat_i[1:0]};

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign acc_ready_i = ~fifo_full;
  assign push        = acc_data_valid_o & acc_ready_i;
  assign pop         = (state == S_WRITE) & dram_wbs_ack_o;

  assign cmd_hit    = cpu_wbs_cyc_i & cpu_wbs_stb_i & cpu_wbs_we_i & (cpu_wbs_adr_i[31:24] == 8'h31);
  // The pending slot frees up on the LOAD edge, so a command arriving then can take it.
  assign cmd_accept = cmd_hit & (~pend_vld | (state == S_LOAD));

  assign busy_o = (state != S_IDLE) | pend_vld;

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= acc_data_o;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state          <= S_IDLE;
      pend_vld       <= 1'b0;
      pend_base      <= '0;
      pend_end       <= '0;
      cur_addr       <= '0;
      end_addr       <= '0;
      dram_wbs_stb_i <= 1'b0;
      dram_wbs_cyc_i <= 1'b0;
      dram_wbs_we_i  <= 1'b0;
      dram_wbs_adr_i <= '0;
      dram_wbs_dat_i <= '0;
      done_o         <= 1'b0;
      drop_o         <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (cmd_hit && !cmd_accept) drop_o <= 1'b1;
      if (state == S_LOAD) pend_vld <= 1'b0;
      if (cmd_accept) begin
        pend_vld  <= 1'b1;
        pend_base <= {cpu_wbs_dat_i[15:10], 2'b00};
        pend_end  <= {cpu_wbs_dat_i[7:2], 2'b00};
      end
      case (state)
        S_IDLE: if (pend_vld) state <= S_LOAD;
        S_LOAD: begin
          cur_addr <= pend_base;
          end_addr <= pend_end;
          state    <= S_WAIT;
        end
        S_WAIT: if (!fifo_empty) begin
          state          <= S_WRITE;
          dram_wbs_stb_i <= 1'b1;
          dram_wbs_cyc_i <= 1'b1;
          dram_wbs_we_i  <= 1'b1;
          dram_wbs_adr_i <= 32'h7800_0200 | {24'd0, cur_addr};
          dram_wbs_dat_i <= 32'(mem[rd_ptr[AW-1:0]]);
        end
        S_WRITE: if (dram_wbs_ack_o) begin
          dram_wbs_stb_i <= 1'b0;
          dram_wbs_cyc_i <= 1'b0;
          dram_wbs_we_i  <= 1'b0;
          dram_wbs_adr_i <= '0;
          dram_wbs_dat_i <= '0;
          if (cur_addr == end_addr) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end else begin
            cur_addr <= cur_addr + 8'd4;
            state    <= S_WAIT;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
